// File: rtl/niosmp_mult_cell_arbiter.sv
// Round-robin arbiter sharing one pipelined 32x32 multiply cell among NUM_REQ requesters.
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   req_valid/src1/src2     per-requester operation request and operands (32 bits per slot)
//   req_ready               one-hot grant, combinational with the accepted request
//   mul_src1/mul_src2       operands to the multiply cell (0 when no grant)
//   mul_result              low 32 bits of the product, MUL_LATENCY clocks after operands
//   rsp_valid/rsp_result    per-requester held result (registered)
//   rsp_ready               requester consumes its result
//   idle                    nothing in flight and no result held
module niosmp_mult_cell_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MUL_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_src1,
  input  logic [NUM_REQ*32-1:0] req_src2,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [31:0]           mul_src1,
  output logic [31:0]           mul_src2,
  input  logic [31:0]           mul_result,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [NUM_REQ*32-1:0] rsp_result,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic                  idle
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  typedef logic [IdxW-1:0] idx_t;

  // busy covers both an in-flight operation and a held, unconsumed result.
  logic [NUM_REQ-1:0]          busy_q, busy_d;
  idx_t                        ptr_q, ptr_d;
  logic [MUL_LATENCY-1:0]      tag_vld_q, tag_vld_d;
  idx_t [MUL_LATENCY-1:0]      tag_idx_q, tag_idx_d;
  logic [NUM_REQ-1:0]          rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ*32-1:0]       rsp_result_q, rsp_result_d;

  logic [NUM_REQ-1:0]          eligible;
  logic [NUM_REQ-1:0]          handshake;
  logic                        gnt_any;
  idx_t                        gnt_idx;

  assign eligible  = req_valid & ~busy_q;
  assign handshake = rsp_valid_q & rsp_ready;

  // Rotating priority search starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [IdxW:0] sum;
    gnt_any = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (IdxW+1)'(k);
      if (sum >= (IdxW+1)'(NUM_REQ)) begin
        sum = sum - (IdxW+1)'(NUM_REQ);
      end
      if (!gnt_any && eligible[sum[IdxW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = sum[IdxW-1:0];
      end
    end
    // No grant may leak out while reset is held.
    if (reset) begin
      gnt_any = 1'b0;
      gnt_idx = '0;
    end
  end

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = gnt_any && (gnt_idx == idx_t'(i));
    end
    mul_src1 = gnt_any ? req_src1[32*gnt_idx +: 32] : 32'h0;
    mul_src2 = gnt_any ? req_src2[32*gnt_idx +: 32] : 32'h0;
  end

  always_comb begin
    busy_d       = (busy_q & ~handshake) | req_ready;
    rsp_valid_d  = rsp_valid_q & ~handshake;
    rsp_result_d = rsp_result_q;
    ptr_d        = ptr_q;
    tag_vld_d    = '0;
    tag_idx_d    = '0;

    if (gnt_any) begin
      ptr_d = (gnt_idx == idx_t'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // Tag pipeline tracks which requester the product emerging from the cell belongs to.
    tag_vld_d[0] = gnt_any;
    tag_idx_d[0] = gnt_idx;
    for (int s = 1; s < int'(MUL_LATENCY); s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end

    // busy blocks reissue, so a capture never collides with a handshake on the same slot.
    if (tag_vld_q[MUL_LATENCY-1]) begin
      rsp_valid_d[tag_idx_q[MUL_LATENCY-1]]            = 1'b1;
      rsp_result_d[32*tag_idx_q[MUL_LATENCY-1] +: 32] = mul_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q       <= '0;
      ptr_q        <= '0;
      tag_vld_q    <= '0;
      tag_idx_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
    end else begin
      busy_q       <= busy_d;
      ptr_q        <= ptr_d;
      tag_vld_q    <= tag_vld_d;
      tag_idx_q    <= tag_idx_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign idle       = ~|busy_q;

endmodule

// File: tb/tb_niosmp_mult_cell_arbiter.sv
module tb_niosmp_mult_cell_arbiter;

  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned MUL_LATENCY = 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_src1;
  logic [NUM_REQ*32-1:0] req_src2;
  logic [NUM_REQ-1:0]    req_ready;
  logic [31:0]           mul_src1;
  logic [31:0]           mul_src2;
  logic [31:0]           mul_result = '0;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ*32-1:0] rsp_result;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic                  idle;

  int n_vec = 0;
  int n_err = 0;

  niosmp_mult_cell_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .MUL_LATENCY (MUL_LATENCY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .req_ready  (req_ready),
    .mul_src1   (mul_src1),
    .mul_src2   (mul_src2),
    .mul_result (mul_result),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_ready  (rsp_ready),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  // Single-stage multiply cell model (MUL_LATENCY = 1).
  always_ff @(posedge clk) mul_result <= mul_src1 * mul_src2;

  // Inputs are driven 2 time units after the rising edge; checks follow a further #1.
  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = '1; rsp_ready = '0;
    req_src1 = {NUM_REQ{32'h11}}; req_src2 = {NUM_REQ{32'h22}};
    cyc; cyc; #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_req_ready got=%b exp=0000", req_ready); end
    n_vec++; if (mul_src1 !== 32'h0) begin n_err++; $display("FAIL rst_mul_src1 got=%h exp=0", mul_src1); end
    n_vec++; if (mul_src2 !== 32'h0) begin n_err++; $display("FAIL rst_mul_src2 got=%h exp=0", mul_src2); end
    req_valid = '0;
    cyc; reset = 1'b0; #1;
    n_vec++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL post_rst_rsp_valid got=%b exp=0000", rsp_valid); end
    n_vec++; if (rsp_result !== '0) begin n_err++; $display("FAIL post_rst_rsp_result got=%h exp=0", rsp_result); end
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL post_rst_idle got=%b exp=1", idle); end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL post_rst_req_ready got=%b exp=0000", req_ready); end
  endtask

  task automatic test_single;
    cyc;
    req_valid = 4'b0001; req_src1[31:0] = 32'd3; req_src2[31:0] = 32'd5; #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
    n_vec++; if (mul_src1 !== 32'd3 || mul_src2 !== 32'd5)
      begin n_err++; $display("FAIL single_operands got=%h,%h exp=3,5", mul_src1, mul_src2); end
    cyc; #1;
    n_vec++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL single_rsp_early got=%b exp=0000", rsp_valid); end
    n_vec++; if (idle !== 1'b0) begin n_err++; $display("FAIL single_idle_busy got=%b exp=0", idle); end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL single_busy_block got=%b exp=0000", req_ready); end
    cyc; #1;
    n_vec++; if (rsp_valid !== 4'b0001) begin n_err++; $display("FAIL single_rsp_valid got=%b exp=0001", rsp_valid); end
    n_vec++; if (rsp_result[31:0] !== 32'h0000000F)
      begin n_err++; $display("FAIL single_result got=%h exp=0000000f", rsp_result[31:0]); end
    cyc; rsp_ready = 4'b0001; #1;
    n_vec++; if (rsp_valid !== 4'b0001 || rsp_result[31:0] !== 32'hF)
      begin n_err++; $display("FAIL single_hold got=%b/%h exp=0001/f", rsp_valid, rsp_result[31:0]); end
    n_vec++; if (idle !== 1'b0) begin n_err++; $display("FAIL single_idle_held got=%b exp=0", idle); end
    cyc; req_valid = '0; rsp_ready = '0; #1;
    n_vec++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL single_consumed got=%b exp=0000", rsp_valid); end
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL single_idle_after got=%b exp=1", idle); end
  endtask

  task automatic test_wrap;
    // ptr is 1 after the single test.
    cyc;
    req_src1[63:32] = 32'hFFFFFFFF; req_src2[63:32] = 32'hFFFFFFFF;
    req_src1[95:64] = 32'h00010000; req_src2[95:64] = 32'h00010000;
    req_valid = 4'b0110; #1;
    n_vec++; if (req_ready !== 4'b0010 || mul_src1 !== 32'hFFFFFFFF)
      begin n_err++; $display("FAIL wrap_grant1 got=%b/%h exp=0010/ffffffff", req_ready, mul_src1); end
    cyc; #1;
    n_vec++; if (req_ready !== 4'b0100 || mul_src1 !== 32'h10000 || mul_src2 !== 32'h10000)
      begin n_err++; $display("FAIL wrap_grant2 got=%b/%h exp=0100/00010000", req_ready, mul_src1); end
    cyc; req_valid = '0; #1;
    n_vec++; if (rsp_valid !== 4'b0010 || rsp_result[63:32] !== 32'h1)
      begin n_err++; $display("FAIL wrap_ffff got=%b/%h exp=0010/00000001", rsp_valid, rsp_result[63:32]); end
    cyc; #1;
    n_vec++; if (rsp_valid !== 4'b0110 || rsp_result[63:32] !== 32'h1 || rsp_result[95:64] !== 32'h0)
      begin n_err++; $display("FAIL wrap_both got=%b/%h/%h exp=0110/1/0", rsp_valid, rsp_result[63:32],
                              rsp_result[95:64]); end
    rsp_ready = 4'b0110;
    cyc; rsp_ready = '0; #1;
    n_vec++; if (rsp_valid !== 4'b0000 || idle !== 1'b1)
      begin n_err++; $display("FAIL wrap_drain got=%b/%b exp=0000/1", rsp_valid, idle); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] prod [4];
    logic [3:0]  eg, ev;
    prod[0] = 32'h200; prod[1] = 32'h303; prod[2] = 32'h408; prod[3] = 32'h50F;
    cyc; reset = 1'b1;
    cyc; reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_src1[32*i +: 32] = 32'(i + 2);
      req_src2[32*i +: 32] = 32'(32'h100 + i);
    end
    req_valid = 4'b1111; rsp_ready = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) cyc;
      #1;
      eg = 4'b0001 << (c % 4);
      ev = (c >= 2) ? 4'b0001 << ((c - 2) % 4) : 4'b0000;
      n_vec++; if (req_ready !== eg)
        begin n_err++; $display("FAIL b2b_grant c=%0d got=%b exp=%b", c, req_ready, eg); end
      n_vec++; if (rsp_valid !== ev)
        begin n_err++; $display("FAIL b2b_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, ev); end
      if (c >= 2) begin
        n_vec++; if (rsp_result[32*((c-2)%4) +: 32] !== prod[(c-2)%4])
          begin n_err++; $display("FAIL b2b_result c=%0d got=%h exp=%h", c,
                                  rsp_result[32*((c-2)%4) +: 32], prod[(c-2)%4]); end
      end
    end
    cyc; req_valid = '0;
    cyc; cyc; cyc; #1;
    n_vec++; if (idle !== 1'b1 || rsp_valid !== 4'b0000)
      begin n_err++; $display("FAIL b2b_drain got=%b/%b exp=1/0000", idle, rsp_valid); end
  endtask

  task automatic test_backpressure;
    logic [3:0] tbl [10];
    tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
            4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000};
    cyc; req_valid = 4'b1111; rsp_ready = 4'b1101;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) cyc;
      #1;
      n_vec++; if (req_ready !== tbl[c])
        begin n_err++; $display("FAIL bp_grant c=%0d got=%b exp=%b", c, req_ready, tbl[c]); end
      if (c >= 3) begin
        n_vec++; if (rsp_valid[1] !== 1'b1 || rsp_result[63:32] !== 32'h303)
          begin n_err++; $display("FAIL bp_hold c=%0d got=%b/%h exp=1/00000303", c, rsp_valid[1],
                                  rsp_result[63:32]); end
      end
    end
    cyc; rsp_ready = 4'b1111; #1;
    n_vec++; if (rsp_valid[1] !== 1'b1 || req_ready !== 4'b0001)
      begin n_err++; $display("FAIL bp_release got=%b/%b exp=1/0001", rsp_valid[1], req_ready); end
    cyc; #1;
    n_vec++; if (rsp_valid[1] !== 1'b0 || req_ready !== 4'b0010)
      begin n_err++; $display("FAIL bp_regrant got=%b/%b exp=0/0010", rsp_valid[1], req_ready); end
    cyc; req_valid = '0;
    cyc; cyc; cyc; #1;
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL bp_drain got=%b exp=1", idle); end
  endtask

  task automatic test_fairness;
    logic [3:0] tbl [3];
    tbl = '{4'b0100, 4'b0001, 4'b0000};
    cyc; reset = 1'b1;
    cyc; reset = 1'b0; req_valid = 4'b0001; rsp_ready = 4'b1111; #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL fair_setup got=%b exp=0001", req_ready); end
    cyc; req_valid = '0;
    cyc; cyc; #1;
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL fair_setup_idle got=%b exp=1", idle); end
    // ptr now 1; requesters 0 and 2 compete.
    req_valid = 4'b0101;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) cyc;
      #1;
      n_vec++; if (req_ready !== tbl[c % 3])
        begin n_err++; $display("FAIL fair_grant c=%0d got=%b exp=%b", c, req_ready, tbl[c % 3]); end
    end
    cyc; req_valid = '0;
    cyc; cyc; cyc; #1;
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("FAIL fair_drain got=%b exp=1", idle); end
  endtask

  task automatic test_reset_midflight;
    cyc; rsp_ready = '0;
    req_src1[127:96] = 32'd7; req_src2[127:96] = 32'd9; req_valid = 4'b1000; #1;
    n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL mid_grant3 got=%b exp=1000", req_ready); end
    cyc; reset = 1'b1; req_valid = 4'b1010; #1;
    n_vec++; if (req_ready !== 4'b0000 || mul_src1 !== 32'h0)
      begin n_err++; $display("FAIL mid_rst_gate got=%b/%h exp=0000/0", req_ready, mul_src1); end
    cyc; reset = 1'b0; #1;
    n_vec++; if (rsp_valid !== 4'b0000 || idle !== 1'b1)
      begin n_err++; $display("FAIL mid_discard got=%b/%b exp=0000/1", rsp_valid, idle); end
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL mid_first_grant got=%b exp=0010", req_ready); end
    cyc; req_valid = '0; #1;
    n_vec++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL mid_no_rsp3 got=%b exp=0000", rsp_valid); end
    cyc; #1;
    n_vec++; if (rsp_valid !== 4'b0010 || rsp_result[63:32] !== 32'h303)
      begin n_err++; $display("FAIL mid_rsp1 got=%b/%h exp=0010/00000303", rsp_valid, rsp_result[63:32]); end
    rsp_ready = 4'b1111;
    cyc; #1;
    n_vec++; if (idle !== 1'b1 || rsp_valid !== 4'b0000)
      begin n_err++; $display("FAIL mid_drain got=%b/%b exp=1/0000", idle, rsp_valid); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_wrap;
    test_back_to_back;
    test_backpressure;
    test_fairness;
    test_reset_midflight;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/niosmp_mult_cell_arbiter.md
Name: niosmp_mult_cell_arbiter

Overview:
- Round-robin arbiter that shares one pipelined 32x32 multiply cell among NUM_REQ requesters.
- The cell returns the low 32 bits of the product after MUL_LATENCY clocks, with no stall.
- Each requester has one outstanding operation and one result holding register; results are returned through a per-requester valid/ready handshake.
- Sits between the custom-instruction/accelerator masters and the single multiplier instance in the niosmp subsystem.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MUL_LATENCY, 1, clocks from operands applied at the cell to result valid at the cell output (1..4)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester operation request
req_src1  in  NUM_REQ*32  operand A; requester i at bits [32i+31:32i]
req_src2  in  NUM_REQ*32  operand B; same packing as req_src1
req_ready  out  NUM_REQ  one-hot grant, combinational, same cycle as the accepted request
mul_src1  out  32  operand A to the multiply cell
mul_src2  out  32  operand B to the multiply cell
mul_result  in  32  cell result, equal to low 32 bits of A*B, MUL_LATENCY clocks after operands
rsp_valid  out  NUM_REQ  result available per requester (registered)
rsp_result  out  NUM_REQ*32  held result per requester; same packing as req_src1
rsp_ready  in  NUM_REQ  requester consumes its result
idle  out  1  high when nothing is in flight and no result is held

Behaviour:
- Reset is synchronous and active-high.
  - Clears busy[NUM_REQ], the tag pipeline, rsp_valid and rsp_result, and sets ptr to 0.
  - In-flight results are discarded.
  - While reset is high, req_ready = 0 and mul_src1/mul_src2 = 0.
  - After reset: idle = 1 and all outputs are 0.
- Eligibility: requester i is eligible when req_valid[i] && !busy[i]. busy[i] is registered; it is set on grant and cleared on the rsp_valid[i] && rsp_ready[i] handshake.
- Arbitration:
  - Search starts at index ptr and wraps modulo NUM_REQ; the first eligible index wins. At most one grant per cycle.
  - req_ready[g] = 1 for the winner only. mul_src1/mul_src2 = the winner's operands; 0 when there is no grant.
- ptr update: after a grant to g, ptr <= (g+1) mod NUM_REQ. With no grant, ptr is held.
- Tag pipeline: MUL_LATENCY stages of {valid, index}. Stage 0 is loaded with {grant, g} at the grant edge.
  - When the last stage is valid, mul_result is the matching product. It is captured into rsp_result slot [index] and rsp_valid[index] <= 1.
- Latency: a grant in cycle T gives rsp_valid high from cycle T+MUL_LATENCY+1.
- Response hold:
  - rsp_valid[i] and rsp_result slot i stay stable until rsp_ready[i].
  - The handshake clears rsp_valid[i] and busy[i] at that edge.
  - Requester i can be granted again no earlier than the cycle after the handshake.
- Throughput:
  - Aggregate: one grant per cycle across distinct requesters.
  - Per requester: at most one grant per MUL_LATENCY+2 cycles.
- rsp_ready[i] while rsp_valid[i] = 0 is ignored. req_valid[i] while busy[i] = 1 is ignored, with req_ready[i] = 0.
- Requester operands need only be stable in the grant cycle; the cell samples them at the grant edge.
- Simultaneous capture and handshake for the same index cannot occur, because busy prevents reissue. All other requesters' captures and handshakes in the same cycle are independent.
- Product arithmetic is unsigned, modulo 2^32. The arbiter never alters the data.
- idle = ~|busy (busy covers both in-flight operations and held results).
- Reset asserted mid-operation: the result of a pre-reset grant emerging after reset is ignored (tags were cleared). No rsp_valid is raised for it.

Test Plan:
- Single request, MUL_LATENCY=1: req0 = 3*5 in cycle 2 -> req_ready[0]=1 in cycle 2; rsp_valid[0]=1 from cycle 4 with rsp_result0 = 0x0000000F; idle low cycles 3..handshake.
- Wrap arithmetic: 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; 0x00010000*0x00010000 -> 0x00000000.
- All four req_valid high from cycle 2 with rsp_ready held high:
  - Grants in order 0,1,2,3 in consecutive cycles 2..5.
  - rsp_valid[0..3] rise in cycles 4..7.
  - Requester 0 is regranted no earlier than cycle 5, and only after ptr wraps back to it.
- Backpressure: rsp_ready[1]=0 for 10 cycles -> rsp_valid[1] and its result stay stable, requester 1 gets no further grant, and other requesters keep being served. Raising rsp_ready[1] clears the response; requester 1 can be granted the next cycle.
- Fairness: req0 and req2 continuously valid, ptr=1 -> grant order 2,0,2,0…; ptr never skips an eligible requester.
- Reset mid-flight: grant req3, then assert reset for 1 cycle at T+1 -> no rsp_valid[3]; busy cleared; idle=1; ptr=0; first grant after reset goes to the lowest eligible index.
